esc_pwm_array: RTL
==================

# esc_pwm_array

Multi-channel successor to the single-ESC PWM generator: drives NUM_CH electronic speed controllers from one shared frame counter, so all rising edges align. Each channel computes pulse = BASE + ((speed + off) << SHIFT), clamps it to MAX_PULSE and double-buffers it, so new setpoints only take effect at a frame boundary. An arm gate forces every output low. Sits between the flight controller's mixer outputs and the motor pins.

## Interface
- NUM_CH, 4, number of ESC channels
- PERIOD_WIDTH, 20, frame counter width; frame = 2^PERIOD_WIDTH cycles
- SPEED_W, 11, per-channel speed width
- OFF_W, 10, per-channel offset width
- SHIFT, 4, left shift applied to speed+off
- BASE, 50000, minimum pulse width in clocks
- MAX_PULSE, 100000, clamp ceiling in clocks; must be ≥ BASE and < 2^PERIOD_WIDTH

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- speed  in  NUM_CH*SPEED_W  packed speeds, channel i at [i*SPEED_W +: SPEED_W]
- off  in  NUM_CH*OFF_W  packed calibration offsets, same packing
- upd  in  1  1-cycle strobe: capture speed/off into pending registers
- arm  in  1  level; 1 enables pulse generation
- pwm  out  NUM_CH  registered PWM per channel
- frame_start  out  1  registered 1-cycle pulse in the first cycle of each frame (cnt==0)
- upd_pending  out  1  high from a captured upd until the next shadow load

## Operation
- Frame counter cnt (PERIOD_WIDTH bits) free-runs, wraps from all-ones to 0.
- Per channel, all arithmetic unsigned:
  - comp = speed + off at SPEED_W+1 bits.
  - raw = BASE + (comp << SHIFT) at PERIOD_WIDTH+1 bits (no overflow before clamp).
  - pend = min(raw, MAX_PULSE).
- On upd: pend registers for all channels load the computed values on that edge; upd_pending <= 1.
- Wrap edge (cnt == all-ones):
  - shadow[i] <= pend[i]; upd_pending <= 0.
  - armed_r <= arm.
  - Every channel with arm == 1 sets pwm <= 1; frame_start <= 1 for one cycle.
- upd in the wrap cycle: pend updates, but shadow takes the old pend. upd_pending stays 1; the new value applies at the following frame.
- Pulse width: pwm[i] high for exactly shadow[i] cycles, cnt = 0 .. shadow[i]-1; low from cnt == shadow[i] to frame end.
- Disarm: arm == 0 drives all pwm low on the next edge, even mid-pulse. armed_r clears.
- Re-arm mid-frame: no pulse until the next wrap; a partial pulse is never emitted.
- pend and shadow are unaffected by arm.

## Timing
- Reset values:
  - cnt = 0; pwm = 0; frame_start = 0; upd_pending = 0; armed_r = 0.
  - pend[i] = shadow[i] = BASE.
  - First frame after reset emits no pulse, because armed_r = 0.
- upd to pwm latency: takes effect at the first wrap edge strictly after the upd edge. Worst case is 2^PERIOD_WIDTH + 1 cycles.
- arm falling edge to pwm low: 1 cycle.
- Rising pwm edges of all armed channels are coincident, same cycle as frame_start.
- rst_n asserted mid-pulse: pwm low immediately (asynchronous); all state returns to reset values.
- Minimum pulse is BASE (speed = off = 0). Ceiling is MAX_PULSE, exact when raw ≥ MAX_PULSE.

## Test plan
Bench overrides for short frames: PERIOD_WIDTH = 12, BASE = 1000, SHIFT = 0, MAX_PULSE = 3000, NUM_CH = 4.
- Reset, arm = 1, no upd → first frame all pwm low. Subsequent frames: each channel high exactly 1000 cycles starting at frame_start; period 4096.
- upd with speeds {0, 100, 500, 1000} and off {0, 10, 20, 30}:
  - Next frame widths are 1000, 1110, 1520, 2030.
  - upd_pending is high until the wrap.
- Channel 2 speed = 2047, off = 1023 (raw 4070) → width clamps to exactly 3000. Other channels are unaffected.
- upd asserted exactly in the cnt == 4095 cycle → the following frame still uses the old widths. The next frame uses the new widths, and upd_pending clears at the second wrap.
- arm dropped at cnt == 500 → all pwm low at cnt == 501. arm restored at cnt == 800 → no pulse until cnt wraps to 0, then full-width pulses.
- rst_n pulsed at cnt == 300 while pwm is high → pwm = 0 asynchronously. Widths revert to 1000, and no pulse occurs in the first post-reset frame.

Source files
------------

// File: rtl/esc_pwm_array_if.sv
// esc_pwm_array_if: bundle between the flight-controller mixer and the
// multi-channel ESC PWM generator.
//   speed       : packed per-channel speeds, channel i at [i*SPEED_W +: SPEED_W]
//   off         : packed per-channel calibration offsets, same packing
//   upd         : 1-cycle strobe, capture speed/off into pending registers
//   arm         : level, 1 enables pulse generation
//   pwm         : per-channel PWM outputs
//   frame_start : 1-cycle pulse in the first cycle of each frame
//   upd_pending : captured setpoints not yet loaded into the shadow registers
// Modports: master = mixer side, slave = PWM generator side.
interface esc_pwm_array_if #(
  parameter int NUM_CH  = 4,
  parameter int SPEED_W = 11,
  parameter int OFF_W   = 10
);
  logic [NUM_CH*SPEED_W-1:0] speed;
  logic [NUM_CH*OFF_W-1:0]   off;
  logic                      upd;
  logic                      arm;
  logic [NUM_CH-1:0]         pwm;
  logic                      frame_start;
  logic                      upd_pending;

  modport master (
    output speed, off, upd, arm,
    input  pwm, frame_start, upd_pending
  );

  modport slave (
    input  speed, off, upd, arm,
    output pwm, frame_start, upd_pending
  );
endinterface

// File: rtl/esc_pwm_array.sv
// esc_pwm_array: NUM_CH-channel ESC PWM generator sharing one free-running
// frame counter so that every armed channel's rising edge is coincident.
// Per channel: pulse = min(BASE + ((speed + off) << SHIFT), MAX_PULSE),
// captured on upd into a pending register and moved into the active shadow
// register only at the frame wrap.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : esc_pwm_array_if slave (speed/off/upd/arm in; pwm/frame_start/
//           upd_pending out, all outputs registered)
module esc_pwm_array #(
  parameter int NUM_CH       = 4,
  parameter int PERIOD_WIDTH = 20,
  parameter int SPEED_W      = 11,
  parameter int OFF_W        = 10,
  parameter int SHIFT        = 4,
  parameter int BASE         = 50000,
  parameter int MAX_PULSE    = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  esc_pwm_array_if.slave    bus
);

  localparam int unsigned CW = SPEED_W + 1;
  localparam int unsigned RW = PERIOD_WIDTH + 1;

  logic [PERIOD_WIDTH-1:0] cnt;
  logic                    wrap;

  logic [CW-1:0]           comp      [NUM_CH];
  logic [RW-1:0]           raw       [NUM_CH];
  logic [PERIOD_WIDTH-1:0] pend_calc [NUM_CH];
  logic [PERIOD_WIDTH-1:0] pend      [NUM_CH];
  logic [PERIOD_WIDTH-1:0] shadow    [NUM_CH];

  logic [NUM_CH-1:0]       pwm;
  logic                    frame_start;
  logic                    upd_pending;
  logic                    armed_r;

  assign wrap = &cnt;

  // Pulse width from setpoint; raw is one bit wider than the counter so the
  // sum cannot overflow before the clamp.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      comp[i]      = CW'(bus.speed[i*SPEED_W +: SPEED_W]) + CW'(bus.off[i*OFF_W +: OFF_W]);
      raw[i]       = RW'(BASE) + (RW'(comp[i]) << SHIFT);
      pend_calc[i] = (raw[i] > RW'(MAX_PULSE)) ? PERIOD_WIDTH'(MAX_PULSE)
                                                : raw[i][PERIOD_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt + PERIOD_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
      upd_pending <= 1'b0;
      armed_r     <= 1'b0;
    end else begin
      frame_start <= wrap;
      // A strobe in the wrap cycle keeps the flag set: its value is only
      // loaded at the following wrap.
      if (bus.upd)   upd_pending <= 1'b1;
      else if (wrap) upd_pending <= 1'b0;
      // armed_r only rises at a wrap, so re-arming mid-frame never yields
      // a partial pulse.
      if (wrap || !bus.arm) armed_r <= bus.arm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        pend[i]   <= PERIOD_WIDTH'(BASE);
        shadow[i] <= PERIOD_WIDTH'(BASE);
      end
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (bus.upd) pend[i]   <= pend_calc[i];
        if (wrap)    shadow[i] <= pend[i];
      end
    end
  end

  // pwm is high for cnt = 0 .. shadow-1, so it is cleared on the edge that
  // leaves cnt == shadow-1. At the wrap the incoming shadow value is pend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (wrap)
          pwm[i] <= bus.arm & (|pend[i]);
        else if (!bus.arm || !armed_r)
          pwm[i] <= 1'b0;
        else if (cnt == shadow[i] - PERIOD_WIDTH'(1))
          pwm[i] <= 1'b0;
      end
    end
  end

  assign bus.pwm         = pwm;
  assign bus.frame_start = frame_start;
  assign bus.upd_pending = upd_pending;

endmodule
